lcd_msg_builder: RTL

LCD_MSG_BUILDER -- requirements
Module: lcd_msg_builder

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_msg_builder_bin2bcd8.sv | 64 ++++++
 rtl/lcd_msg_builder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD message-builder definitions: FSM states, HD44780 constants and message text.
// The optional "Parking FULL" text is compiled in only with LCD_MSG_FULL_TEXT_EN.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CONV      = 3'd1,
    ST_SEND_CMD  = 3'd2,
    ST_SEND_TEXT = 3'd3
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam int         MSG_LEN       = 16;

  // Index 0 is the leftmost character on the display.
  localparam logic [0:11][7:0] MSG_PREFIX = "Free slots: ";
`ifdef LCD_MSG_FULL_TEXT_EN
  localparam logic [0:15][7:0] FULL_TEXT  = "Parking FULL    ";
`endif

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    digit_char = ASCII_ZERO | {4'd0, d};
  endfunction

endpackage

// File: rtl/lcd_msg_builder_bin2bcd8.sv
// Sequential double-dabble: 8-bit binary to three BCD digits in 8 shift cycles.
// done is high during the final shift cycle; digits are valid from the next cycle on.
module bin2bcd8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] units
);

  logic [19:0] sh_q, sh_d, adj_s;
  logic [2:0]  cnt_q, cnt_d;
  logic        run_q, run_d;

  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // Next-state of the shift register and step counter
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    run_d = run_q;
    adj_s = {add3(sh_q[19:16]), add3(sh_q[15:12]), add3(sh_q[11:8]), sh_q[7:0]};
    if (start) begin
      sh_d  = {12'd0, bin};
      cnt_d = 3'd0;
      run_d = 1'b1;
    end else if (run_q) begin
      sh_d  = adj_s << 5'd1;
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        run_d = 1'b0;
      end else begin
        run_d = run_q;
      end
    end else begin
      sh_d  = sh_q;
      cnt_d = cnt_q;
    end
  end

  // Conversion state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q  <= 20'd0;
      cnt_q <= 3'd0;
      run_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done     = run_q && (cnt_q == 3'd7);
  assign hundreds = sh_q[19:16];
  assign tens     = sh_q[15:12];
  assign units    = sh_q[11:8];

endmodule

// File: rtl/lcd_msg_builder.sv
// Builds the 17-byte LCD line-2 update (cursor command + 16 chars) showing the free-slot count.
// Optional macro LCD_MSG_FULL_TEXT_EN prints "Parking FULL    " when the count is zero.
module lcd_msg_builder
  import lcd_pkg::*;
#(
  parameter int CAPACITY = 200,
  parameter int MSG_LEN  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] free_slots,
  input  logic       update,
  output logic [7:0] byte_data,
  output logic       byte_rs,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       busy
);

  localparam logic [7:0] CAP_MAX  = 8'(CAPACITY);
  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  lcd_state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       pending_q, pending_d;
  logic       busy_q, busy_d;
  logic       valid_q, valid_d;
  logic       rs_q, rs_d;
  logic [7:0] data_q, data_d;
`ifdef LCD_MSG_FULL_TEXT_EN
  logic       full_q, full_d;
`endif

  logic [7:0] clamped_s;
  logic [3:0] char_sel_s;
  logic [7:0] next_char_s;
  logic       bcd_start_s, bcd_done_s;
  logic [3:0] dig_h_s, dig_t_s, dig_u_s;

  function automatic logic [7:0] text_char(input logic [3:0] idx, input logic [3:0] h,
                                           input logic [3:0] t, input logic [3:0] u);
    logic [7:0] c;
    case (idx)
      4'd12:   c = (h == 4'd0) ? ASCII_SPACE : digit_char(h);
      4'd13:   c = ((h == 4'd0) && (t == 4'd0)) ? ASCII_SPACE : digit_char(t);
      4'd14:   c = digit_char(u);
      4'd15:   c = ASCII_SPACE;
      default: c = MSG_PREFIX[idx];
    endcase
    return c;
  endfunction

  bin2bcd8 u_bcd (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (bcd_start_s),
    .bin      (clamped_s),
    .done     (bcd_done_s),
    .hundreds (dig_h_s),
    .tens     (dig_t_s),
    .units    (dig_u_s)
  );

  assign clamped_s = (free_slots > CAP_MAX) ? CAP_MAX : free_slots;

  // Character to present after the current transfer: index 0 after the command
  always_comb begin
    char_sel_s = (state_q == ST_SEND_CMD) ? 4'd0 : (idx_q + 4'd1);
`ifdef LCD_MSG_FULL_TEXT_EN
    if (full_q) begin
      next_char_s = FULL_TEXT[char_sel_s];
    end else begin
      next_char_s = text_char(char_sel_s, dig_h_s, dig_t_s, dig_u_s);
    end
`else
    next_char_s = text_char(char_sel_s, dig_h_s, dig_t_s, dig_u_s);
`endif
  end

  // Message FSM next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    valid_d     = valid_q;
    rs_d        = rs_q;
    data_d      = data_q;
    bcd_start_s = 1'b0;
`ifdef LCD_MSG_FULL_TEXT_EN
    full_d      = full_q;
`endif
    // Any update outside IDLE, including the final-transfer cycle, is deferred
    if ((state_q != ST_IDLE) && update) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (update || pending_q) begin
          state_d     = ST_CONV;
          busy_d      = 1'b1;
          pending_d   = 1'b0;
          idx_d       = 4'd0;
          bcd_start_s = 1'b1;
`ifdef LCD_MSG_FULL_TEXT_EN
          full_d      = (clamped_s == 8'd0);
`endif
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_CONV: begin
        if (bcd_done_s) begin
          state_d = ST_SEND_CMD;
          valid_d = 1'b1;
          rs_d    = 1'b0;
          data_d  = LCD_CMD_LINE2;
        end else begin
          valid_d = 1'b0;
        end
      end
      ST_SEND_CMD: begin
        if (byte_ready) begin
          state_d = ST_SEND_TEXT;
          idx_d   = 4'd0;
          rs_d    = 1'b1;
          data_d  = next_char_s;
        end else begin
          state_d = ST_SEND_CMD;
        end
      end
      ST_SEND_TEXT: begin
        if (byte_ready && (idx_q == LAST_IDX)) begin
          state_d = ST_IDLE;
          idx_d   = 4'd0;
          busy_d  = 1'b0;
          valid_d = 1'b0;
          rs_d    = 1'b0;
          data_d  = 8'h00;
        end else if (byte_ready) begin
          idx_d  = idx_q + 4'd1;
          data_d = next_char_s;
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        rs_d    = 1'b0;
        data_d  = 8'h00;
      end
    endcase
  end

  // FSM and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= 4'd0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      rs_q      <= 1'b0;
      data_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      rs_q      <= rs_d;
      data_q    <= data_d;
    end
  end

`ifdef LCD_MSG_FULL_TEXT_EN
  // Latched zero-count flag selecting the FULL text
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end
`endif

  assign byte_data  = data_q;
  assign byte_rs    = rs_q;
  assign byte_valid = valid_q;
  assign busy       = busy_q;

endmodule
